// File: rtl/lbp_engine.sv
// Local Binary Pattern engine: streams a grey image through a sliding 3x3 window
// and writes one 8-bit LBP code per pixel (optionally zeroing the border) in raster order.
module lbp_engine #(
  parameter int unsigned W_LOG2      = 7,
  parameter int unsigned H_LOG2      = 7,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned BORDER_ZERO = 1,
  parameter int unsigned CMP_GE      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [W_LOG2+H_LOG2-1:0] gray_addr,
  output logic                     gray_req,
  input  logic                     gray_ready,
  input  logic [PIX_W-1:0]         gray_data,
  output logic [W_LOG2+H_LOG2-1:0] lbp_addr,
  output logic                     lbp_valid,
  output logic [7:0]               lbp_data,
  output logic                     finish
);

  localparam int unsigned AW = W_LOG2 + H_LOG2;
  localparam logic [AW-1:0]     LAST  = '1;
  localparam logic [AW-1:0]     ROW   = AW'(1) << W_LOG2;
  localparam logic [AW-1:0]     FIRST = (BORDER_ZERO != 0) ? '0 : ROW + AW'(1);
  localparam logic [W_LOG2-1:0] X_MAX = '1;
  localparam logic [H_LOG2-1:0] Y_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_BORDER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cur_q, cur_d;
  logic [3:0]       rd_idx_q, rd_idx_d;
  logic [3:0]       need_q, need_d;
  logic             full_q, full_d;
  logic             pend_q, pend_d;
  logic [3:0]       pend_slot_q, pend_slot_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [AW-1:0]    gray_addr_q, gray_addr_d;
  logic             gray_req_q, gray_req_d;
  logic [AW-1:0]    lbp_addr_q, lbp_addr_d;
  logic             lbp_valid_q, lbp_valid_d;
  logic [7:0]       lbp_data_q, lbp_data_d;
  logic             finish_q, finish_d;

  logic             do_enter;
  logic [AW-1:0]    tgt_addr, adv_addr;
  logic             tgt_done, adv_done;
  logic [3:0]       slot;
  logic [3:0]       rd_next;

  function automatic logic cmp(input logic [PIX_W-1:0] n, input logic [PIX_W-1:0] c);
    return (CMP_GE != 0) ? (n >= c) : (n > c);
  endfunction

  function automatic logic [7:0] lbp_code(input logic [PIX_W-1:0] w [3][3]);
    logic [PIX_W-1:0] c;
    c = w[1][1];
    return {cmp(w[2][2], c), cmp(w[1][2], c), cmp(w[0][2], c), cmp(w[2][1], c),
            cmp(w[0][1], c), cmp(w[2][0], c), cmp(w[1][0], c), cmp(w[0][0], c)};
  endfunction

  // Read index -> {col,row} of the window: full load walks columns top to bottom,
  // incremental load fills only the rightmost column.
  function automatic logic [3:0] slot_cr(input logic full, input logic [3:0] i);
    logic [1:0] col, row;
    if (full) begin
      col = (i >= 4'd6) ? 2'd2 : (i >= 4'd3) ? 2'd1 : 2'd0;
      row = 2'(i - 4'(col) * 4'd3);
    end else begin
      col = 2'd2;
      row = i[1:0];
    end
    return {col, row};
  endfunction

  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] c, input logic full,
                                             input logic [3:0] i);
    logic [3:0] cr;
    cr = slot_cr(full, i);
    return c + (AW'(cr[1:0]) << W_LOG2) + AW'(cr[3:2]) - ROW - AW'(1);
  endfunction

  function automatic logic is_interior(input logic [AW-1:0] a);
    logic [W_LOG2-1:0] x;
    logic [H_LOG2-1:0] y;
    x = a[W_LOG2-1:0];
    y = a[AW-1:W_LOG2];
    return (x != '0) && (x != X_MAX) && (y != '0) && (y != Y_MAX);
  endfunction

  always_comb begin
    if (BORDER_ZERO != 0) begin
      adv_done = (cur_q == LAST);
      adv_addr = cur_q + AW'(1);
    end else if (cur_q[W_LOG2-1:0] == X_MAX - 1'b1) begin
      // last interior column: skip right border and left border of the next row
      adv_done = (cur_q[AW-1:W_LOG2] == Y_MAX - 1'b1);
      adv_addr = cur_q + AW'(3);
    end else begin
      adv_done = 1'b0;
      adv_addr = cur_q + AW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rd_idx_d    = rd_idx_q;
    need_d      = need_q;
    full_d      = full_q;
    pend_d      = 1'b0;
    pend_slot_d = pend_slot_q;
    win_d       = win_q;
    gray_addr_d = gray_addr_q;
    gray_req_d  = gray_req_q;
    lbp_addr_d  = lbp_addr_q;
    lbp_valid_d = 1'b0;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;
    do_enter    = 1'b0;
    tgt_addr    = adv_addr;
    tgt_done    = adv_done;
    slot        = slot_cr(full_q, pend_slot_q);
    rd_next     = rd_idx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        do_enter = 1'b1;
        tgt_addr = FIRST;
        tgt_done = 1'b0;
      end
      S_FETCH: begin
        if (pend_q) begin
          win_d[slot[3:2]][slot[1:0]] = gray_data;
          if (pend_slot_q == need_q - 4'd1) begin
            state_d     = S_WRITE;
            lbp_valid_d = 1'b1;
            lbp_addr_d  = cur_q;
            lbp_data_d  = lbp_code(win_d);
          end
        end
        if (gray_req_q && gray_ready) begin
          pend_d      = 1'b1;
          pend_slot_d = rd_idx_q;
          rd_idx_d    = rd_next;
          if (rd_next < need_q) gray_addr_d = rd_addr(cur_q, full_q, rd_next);
          else                  gray_req_d  = 1'b0;
        end
      end
      S_WRITE, S_BORDER: do_enter = 1'b1;
      default: ;
    endcase

    if (do_enter) begin
      cur_d = tgt_addr;
      if (tgt_done) begin
        state_d    = S_DONE;
        finish_d   = 1'b1;
        gray_req_d = 1'b0;
      end else if (is_interior(tgt_addr)) begin
        state_d  = S_FETCH;
        full_d   = (tgt_addr[W_LOG2-1:0] == W_LOG2'(1));
        need_d   = full_d ? 4'd9 : 4'd3;
        rd_idx_d = '0;
        if (!full_d) begin
          win_d[0] = win_q[1];
          win_d[1] = win_q[2];
        end
        gray_req_d  = 1'b1;
        gray_addr_d = rd_addr(tgt_addr, full_d, 4'd0);
      end else begin
        state_d     = S_BORDER;
        lbp_valid_d = 1'b1;
        lbp_data_d  = '0;
        lbp_addr_d  = tgt_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rd_idx_q    <= '0;
      need_q      <= '0;
      full_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      for (int unsigned c = 0; c < 3; c++)
        for (int unsigned r = 0; r < 3; r++)
          win_q[c][r] <= '0;
      gray_addr_q <= '0;
      gray_req_q  <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_valid_q <= 1'b0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rd_idx_q    <= rd_idx_d;
      need_q      <= need_d;
      full_q      <= full_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      win_q       <= win_d;
      gray_addr_q <= gray_addr_d;
      gray_req_q  <= gray_req_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  assign gray_addr = gray_addr_q;
  assign gray_req  = gray_req_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine on an 8x8 image: three configurations (border zero / interior only /
// strict compare), table-driven runs with a reference-model scoreboard plus a mid-run reset.
module tb_lbp_engine;

  typedef struct {
    int cfg;        // 0: BZ=1 GE=1, 1: BZ=0 GE=1, 2: BZ=1 GE=0
    int pat;        // 0: flat 0x40, 1: ramp, 2: random
    bit rnd;        // random gray_ready
    int n_writes;
    int n_reads;
    int code;       // required interior code, -1 = model only
  } vec_t;

  typedef struct {
    int       addr;
    bit [7:0] data;
    bit       interior;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic       gray_ready = 1'b1;
  logic [7:0] gray_data = '0;
  logic [5:0] g_addr [3];
  logic       g_req  [3];
  logic [5:0] l_addr [3];
  logic       l_valid[3];
  logic [7:0] l_data [3];
  logic       fin    [3];

  int   sel = 0;
  bit   rnd = 1'b0;
  bit   active = 1'b0;
  int   exp_code = -1;
  int   first_exp = 0;
  int   wbase = 0;
  int   errors = 0;
  int   checks = 0;
  int   writes = 0;
  int   reads = 0;
  logic [7:0] img [64];
  exp_t exp_q [$];
  exp_t e;
  int   dxs [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int   dys [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  logic       m_req, m_valid, m_fin;
  logic [5:0] m_addr, m_laddr;
  logic [7:0] m_ldata;
  assign m_req   = g_req[sel];
  assign m_addr  = g_addr[sel];
  assign m_valid = l_valid[sel];
  assign m_laddr = l_addr[sel];
  assign m_ldata = l_data[sel];
  assign m_fin   = fin[sel];

  always #5 clk = ~clk;

  lbp_engine #(.W_LOG2(3), .H_LOG2(3), .PIX_W(8), .BORDER_ZERO(1), .CMP_GE(1)) u_dut_a (
    .clk(clk), .reset(rst[0]), .gray_addr(g_addr[0]), .gray_req(g_req[0]),
    .gray_ready(gray_ready), .gray_data(gray_data), .lbp_addr(l_addr[0]),
    .lbp_valid(l_valid[0]), .lbp_data(l_data[0]), .finish(fin[0]));
  lbp_engine #(.W_LOG2(3), .H_LOG2(3), .PIX_W(8), .BORDER_ZERO(0), .CMP_GE(1)) u_dut_b (
    .clk(clk), .reset(rst[1]), .gray_addr(g_addr[1]), .gray_req(g_req[1]),
    .gray_ready(gray_ready), .gray_data(gray_data), .lbp_addr(l_addr[1]),
    .lbp_valid(l_valid[1]), .lbp_data(l_data[1]), .finish(fin[1]));
  lbp_engine #(.W_LOG2(3), .H_LOG2(3), .PIX_W(8), .BORDER_ZERO(1), .CMP_GE(0)) u_dut_c (
    .clk(clk), .reset(rst[2]), .gray_addr(g_addr[2]), .gray_req(g_req[2]),
    .gray_ready(gray_ready), .gray_data(gray_data), .lbp_addr(l_addr[2]),
    .lbp_valid(l_valid[2]), .lbp_data(l_data[2]), .finish(fin[2]));

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Grey memory: data appears the cycle after an accepted request.
  always @(posedge clk) begin
    if (m_req && gray_ready) begin
      gray_data <= img[m_addr];
      if (active) reads++;
    end
  end

  // Ready driver plus hold check: a stalled request must keep req and addr.
  logic       p_req = 1'b0, p_ready = 1'b1;
  logic [5:0] p_addr = '0;
  always @(negedge clk) begin
    if (active && rnd && p_req && !p_ready)
      check(m_req == 1'b1 && m_addr == p_addr, "stall_hold", int'(m_addr), int'(p_addr));
    p_req   = m_req;
    p_addr  = m_addr;
    gray_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    p_ready = gray_ready;
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (active && m_valid) begin
      if (writes == wbase)
        check(int'(m_laddr) == first_exp, "first_addr", int'(m_laddr), first_exp);
      writes++;
      if (exp_q.size() == 0) begin
        check(1'b0, "extra_write", int'(m_laddr), -1);
      end else begin
        e = exp_q.pop_front();
        check(int'(m_laddr) == e.addr, "wr_addr", int'(m_laddr), e.addr);
        check(m_ldata == e.data, "wr_data", int'(m_ldata), int'(e.data));
        if (e.interior && exp_code >= 0)
          check(int'(m_ldata) == exp_code, "interior_code", int'(m_ldata), exp_code);
      end
    end
  end

  task automatic fill_img(input int pat);
    for (int a = 0; a < 64; a++)
      case (pat)
        0:       img[a] = 8'h40;
        1:       img[a] = 8'(a);
        default: img[a] = 8'($urandom_range(0, 255));
      endcase
  endtask

  task automatic build_expect(input int cfg);
    bit bz, ge;
    exp_t r;
    bz = (cfg != 1);
    ge = (cfg != 2);
    exp_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        r.addr = y * 8 + x;
        r.interior = (x > 0 && x < 7 && y > 0 && y < 7);
        r.data = '0;
        if (r.interior) begin
          for (int k = 0; k < 8; k++) begin
            logic [7:0] n, c;
            n = img[(y + dys[k]) * 8 + x + dxs[k]];
            c = img[y * 8 + x];
            r.data[k] = ge ? (n >= c) : (n > c);
          end
          exp_q.push_back(r);
        end else if (bz) begin
          exp_q.push_back(r);
        end
      end
    first_exp = bz ? 0 : 9;
  endtask

  task automatic wait_finish_and_check(input vec_t v, input int rbase);
    int n, bad;
    n = 0;
    while (!m_fin && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(m_fin == 1'b1, "finish_reached", int'(m_fin), 1);
    @(negedge clk);
    check(writes - wbase == v.n_writes, "write_count", writes - wbase, v.n_writes);
    check(exp_q.size() == 0, "missing_writes", exp_q.size(), 0);
    check(reads - rbase == v.n_reads, "read_count", reads - rbase, v.n_reads);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!m_fin || m_valid || m_req) bad++;
    end
    check(bad == 0, "done_hold", bad, 0);
  endtask

  task automatic run_vector(input vec_t v);
    int rbase;
    active = 1'b0;
    rst = 3'b111;
    @(negedge clk);
    sel = v.cfg;
    rnd = v.rnd;
    exp_code = v.code;
    fill_img(v.pat);
    build_expect(v.cfg);
    @(negedge clk);
    wbase = writes;
    rbase = reads;
    active = 1'b1;
    rst[sel] = 1'b0;
    wait_finish_and_check(v, rbase);
    active = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{cfg: 0, pat: 0, rnd: 1'b0, n_writes: 64, n_reads: 144, code: 8'hFF};
    vecs[1] = '{cfg: 0, pat: 1, rnd: 1'b0, n_writes: 64, n_reads: 144, code: 8'hF0};
    vecs[2] = '{cfg: 1, pat: 1, rnd: 1'b0, n_writes: 36, n_reads: 144, code: 8'hF0};
    vecs[3] = '{cfg: 0, pat: 1, rnd: 1'b1, n_writes: 64, n_reads: 144, code: 8'hF0};
    vecs[4] = '{cfg: 2, pat: 0, rnd: 1'b0, n_writes: 64, n_reads: 144, code: 8'h00};
    vecs[5] = '{cfg: 0, pat: 2, rnd: 1'b1, n_writes: 64, n_reads: 144, code: -1};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check(g_req[i] == 0 && g_addr[i] == 0 && l_valid[i] == 0 && l_data[i] == 0 &&
            l_addr[i] == 0 && fin[i] == 0, "reset_state",
            int'({g_req[i], g_addr[i], l_valid[i], l_data[i], l_addr[i], fin[i]}), 0);

    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // Reset in the middle of a run, then a full clean run from address 0.
    begin
      int rbase;
      rst = 3'b111;
      sel = 0;
      rnd = 1'b0;
      exp_code = 8'hF0;
      fill_img(1);
      build_expect(0);
      @(negedge clk);
      wbase = writes;
      active = 1'b1;
      rst[0] = 1'b0;
      repeat (150) @(negedge clk);
      active = 1'b0;
      #2 rst[0] = 1'b1;
      #1 check(g_req[0] == 0 && g_addr[0] == 0 && l_valid[0] == 0 && l_data[0] == 0 &&
               l_addr[0] == 0 && fin[0] == 0, "midrun_reset",
               int'({g_req[0], g_addr[0], l_valid[0], l_data[0], l_addr[0], fin[0]}), 0);
      build_expect(0);
      @(negedge clk);
      wbase = writes;
      rbase = reads;
      active = 1'b1;
      rst[0] = 1'b0;
      wait_finish_and_check(vecs[1], rbase);
      active = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
